// File: rtl/lpc_dual_port_buffer.sv
// True-dual-port sample buffer with two Avalon-MM slave ports on one clock.
// Reads are registered through a READ_LATENCY-deep pipeline with a valid
// strobe; a clear engine zero-fills the whole array after reset or on demand.
module lpc_dual_port_buffer #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 10,
    parameter int READ_LATENCY   = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     s1_address,
    input  logic                  s1_chipselect,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    input  logic [DATA_W-1:0]     s1_writedata,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,
    output logic                  s1_waitrequest,
    input  logic [ADDR_W-1:0]     s2_address,
    input  logic                  s2_chipselect,
    input  logic                  s2_read,
    input  logic                  s2_write,
    input  logic [DATA_W/8-1:0]   s2_byteenable,
    input  logic [DATA_W-1:0]     s2_writedata,
    output logic [DATA_W-1:0]     s2_readdata,
    output logic                  s2_readdatavalid,
    output logic                  s2_waitrequest,
    input  logic                  clear_req,
    output logic                  clear_busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clrAddr_q, clrAddr_d;
    logic              clearing;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              s1Acc, s1Wr, s1Rd;
    logic              s2Acc, s2Wr, s2Rd;
    logic [1:0]        rdAcc;
    logic [ADDR_W-1:0] rdAddr [2];

    logic [DATA_W-1:0]       pipeData_q  [2][READ_LATENCY];
    logic [READ_LATENCY-1:0] pipeValid_q [2];

    // A request is taken only while the clear engine is idle; read+write together counts as a write
    assign s1Acc = s1_chipselect & (s1_read | s1_write) & ~clearing;
    assign s2Acc = s2_chipselect & (s2_read | s2_write) & ~clearing;
    assign s1Wr  = s1Acc & s1_write;
    assign s2Wr  = s2Acc & s2_write;
    assign s1Rd  = s1Acc & s1_read & ~s1_write;
    assign s2Rd  = s2Acc & s2_read & ~s2_write;

    assign rdAcc     = {s2Rd, s1Rd};
    assign rdAddr[0] = s1_address;
    assign rdAddr[1] = s2_address;

    // Clear engine state and sweep address register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clrAddr_q <= '0;
        end else begin
            state_q   <= state_d;
            clrAddr_q <= clrAddr_d;
        end
    end

    // Clear engine next state: a request while sweeping is ignored, the sweep ends after the top address
    always_comb begin
        state_d   = state_q;
        clrAddr_d = clrAddr_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d   = CLEAR;
                    clrAddr_d = '0;
                end
            end
            CLEAR: begin
                clrAddr_d = clrAddr_q + 1'b1;
                if (clrAddr_q == {ADDR_W{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear engine outputs: both ports stall for the whole sweep
    always_comb begin
        clearing = (state_q == CLEAR);
    end

    assign clear_busy     = clearing;
    assign s1_waitrequest = clearing;
    assign s2_waitrequest = clearing;

    // Array update: zero-fill during a sweep, otherwise byte-lane host writes where s1 owns contested lanes
    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[clrAddr_q] <= '0;
        end else begin
            for (int b = 0; b < BE_W; b++) begin
                if (s2Wr && s2_byteenable[b]) begin
                    mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
                end
                if (s1Wr && s1_byteenable[b]) begin
                    mem[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
                end
            end
        end
    end

    // Read pipeline per port: stage 0 samples the pre-write array, later stages advance only with valid data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < 2; p++) begin
                pipeValid_q[p] <= '0;
                for (int s = 0; s < READ_LATENCY; s++) begin
                    pipeData_q[p][s] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                pipeValid_q[p][0] <= rdAcc[p];
                if (rdAcc[p]) begin
                    pipeData_q[p][0] <= mem[rdAddr[p]];
                end
                for (int s = 1; s < READ_LATENCY; s++) begin
                    pipeValid_q[p][s] <= pipeValid_q[p][s-1];
                    if (pipeValid_q[p][s-1]) begin
                        pipeData_q[p][s] <= pipeData_q[p][s-1];
                    end
                end
            end
        end
    end

    assign s1_readdata      = pipeData_q[0][READ_LATENCY-1];
    assign s2_readdata      = pipeData_q[1][READ_LATENCY-1];
    assign s1_readdatavalid = pipeValid_q[0][READ_LATENCY-1];
    assign s2_readdatavalid = pipeValid_q[1][READ_LATENCY-1];

endmodule

// File: doc/lpc_dual_port_buffer.md
# lpc_dual_port_buffer

Parametrised true-dual-port sample buffer with two Avalon-MM slave ports (s1, s2) on a single clock, a configurable registered read pipeline with `readdatavalid`, defined write-collision and mixed-port read-during-write behaviour, and a hardware clear engine that zero-fills the array after reset or on request. It replaces fixed 32x1024 unregistered source/coefficient RAMs between the Nios-side interconnect and the LPC analysis datapath, where the DSP side needs pipelined reads and a guaranteed-clean buffer between frames.

## Interface
- `DATA_W`, 32: word width; multiple of 8.
- `ADDR_W`, 10: word address width; depth = 2^ADDR_W.
- `READ_LATENCY`, 1: cycles from read acceptance to `readdatavalid`; legal values 1 or 2.
- `CLEAR_ON_RESET`, 1: 1 = run a clear sweep automatically on reset release.

Ports:
- `clk` in 1: single clock for both ports.
- `reset_n` in 1: asynchronous, active-low reset.
- `s1_address` / `s2_address` in ADDR_W: word address.
- `s1_chipselect` / `s2_chipselect` in 1: port select.
- `s1_read` / `s2_read` in 1: read request.
- `s1_write` / `s2_write` in 1: write request.
- `s1_byteenable` / `s2_byteenable` in DATA_W/8: byte lanes.
- `s1_writedata` / `s2_writedata` in DATA_W: write data.
- `s1_readdata` / `s2_readdata` out DATA_W: read data.
- `s1_readdatavalid` / `s2_readdatavalid` out 1: one-cycle valid strobe.
- `s1_waitrequest` / `s2_waitrequest` out 1: high while the clear engine runs.
- `clear_req` in 1: one-cycle pulse starting a clear sweep.
- `clear_busy` out 1: high while the sweep runs.

## Operation
- Accept: a port accepts a request in a cycle where `chipselect & (read|write) & !waitrequest`. If `read` and `write` are both high, the request is a write; no `readdatavalid` is produced.
- Write: only lanes with `byteenable` set are updated; an all-zero `byteenable` writes nothing.
- Write collision (both ports write the same address in one cycle): per byte, the s1 lane wins where s1 enables it; s2 lanes enabled only by s2 are written.
- Mixed-port read-during-write (one port writes X, the other reads X in the same cycle): the reader returns the old data.
- Same-port read of a previously written address returns the new data. There is no same-cycle read/write on one port.
- Clear engine FSM, states IDLE and CLEAR:
  - Reset enters CLEAR when `CLEAR_ON_RESET`=1, otherwise IDLE.
  - IDLE -> CLEAR on `clear_req`.
  - In CLEAR, an ADDR_W-bit counter writes zeros to all lanes at addresses 0..2^ADDR_W-1, one per cycle.
  - CLEAR -> IDLE after address 2^ADDR_W-1 is written.
  - `clear_req` during CLEAR is ignored; the sweep does not restart.
- Both `waitrequest` outputs equal `clear_busy`. Host writes and reads are not accepted during CLEAR.
- Reads accepted before the sweep starts drain normally and return pre-clear data.

## Timing
- Reset values: `readdata` 0, `readdatavalid` 0, `clear_busy` = `waitrequest` = CLEAR_ON_RESET, clear counter 0, read pipeline flushed.
- Read accepted at cycle T: `readdata` and `readdatavalid` are presented at T+READ_LATENCY. `readdatavalid` is high for exactly one cycle per accepted read.
- `readdata` holds its last value between valids.
- Back-to-back reads are accepted every cycle; throughput is 1 read per cycle per port.
- Write accepted at T: the data is visible to a read accepted at T+1 on either port.
- Clear timing:
  - `clear_req` sampled high at T (IDLE): `clear_busy` is high from T+1.
  - Zero writes occur at T+1 .. T+2^ADDR_W.
  - `clear_busy` is low at T+2^ADDR_W+1.
  - Reset-triggered sweep: first zero write in the first clock after `reset_n` deasserts; duration is 2^ADDR_W cycles.
- `reset_n` asserted mid-sweep: the counter returns to 0, and the sweep restarts from 0 on release if `CLEAR_ON_RESET`=1. Otherwise the state is IDLE with the array partially cleared; this is legal and is not reported.
- `reset_n` asserted with reads in flight: the pipeline is flushed and no `readdatavalid` is produced for those reads.
- Memory contents are not reset by `reset_n`; only the sweep clears them.

## Test plan
- Reset sweep, defaults: release `reset_n` -> `clear_busy`/`waitrequest` high for 1024 cycles then low; s2 reads of addresses 0, 511, 1023 return 0x00000000 with `readdatavalid` 1 cycle after acceptance.
- Byte lanes: s1 writes 0xAABBCCDD, be=0xF, to addr 5, then 0x11223344 with be=0x5 -> s2 read of addr 5 returns 0xAA22CC44.
- Collision: same cycle, s1 writes 0x000000FF be=0x1 and s2 writes 0x12345678 be=0xF to addr 9 -> read returns 0x123456FF.
- Mixed-port read-during-write: addr 3 holds 0x1; s1 writes 0x2 while s2 reads addr 3 in the same cycle -> s2 gets 0x1; an s2 read on the next cycle gets 0x2.
- READ_LATENCY=2, streaming: s1 reads addrs 0..7 on consecutive cycles -> 8 consecutive `readdatavalid` pulses starting 2 cycles after the first acceptance, with data in order.
- Clear interaction: `clear_req` while 2 reads are in flight -> both reads deliver old data. A second `clear_req` mid-sweep does not extend `clear_busy` beyond 1024 cycles. `reset_n` pulsed at sweep cycle 300 -> a fresh 1024-cycle sweep follows.
